// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit and its output buffer.
package ifetch_unit_pkg;

  localparam int              XLEN       = 32;
  localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_BYTES = 32'd4;

  // One buffered fetch result: the byte address and the word returned for it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Force an address onto an instruction boundary.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(INST_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/ifetch_unit_fifo.sv
// fetch_fifo: small in-order buffer of fetched {pc, inst} entries.
// push and pop may coincide when full; flush empties the buffer and wins
// over push/pop in the same cycle. BUF_DEPTH must be 2 or 4.
module fetch_fifo
  import ifetch_unit_pkg::*;
#(
  parameter  int BUF_DEPTH = 2,
  localparam int PW        = $clog2(BUF_DEPTH),
  localparam int CW        = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [BUF_DEPTH];
  fetch_entry_t  mem_d [BUF_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != CW'(BUF_DEPTH)) | do_pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Register buffer state; reset discards everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetcher against a fixed 1-cycle
// memory, with a small output buffer and single-cycle redirect/flush.
//
// Output handshake: an entry transfers on a rising edge where out_valid and
// out_ready are both 1. out_valid/out_inst/out_pc depend only on registered
// state (never on out_ready), and a presented entry stays stable until it
// transfers or a redirect/reset removes it.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  // One extra bit so count + inflight never overflows before the compare.
  localparam int OW = CW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] issued_pc_q, issued_pc_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic [OW-1:0]   occupancy;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  // Issue decision: only fetch when the word is guaranteed a buffer slot.
  always_comb begin
    pop         = out_valid & out_ready;
    push        = inflight_q & ~redirect_valid;
    occupancy   = OW'(count) + OW'(inflight_q) - OW'(pop);
    issue       = ~redirect_valid & (occupancy < OW'(BUF_DEPTH));
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
    end else if (issue) begin
      fetch_pc_d  = fetch_pc_q + INST_BYTES;
      issued_pc_d = fetch_pc_q;
      inflight_d  = 1'b1;
    end
  end

  // Fetch pointer and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q  <= align_pc(RESET_PC);
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
    end
  end

  assign push_entry = '{pc: issued_pc_q, inst: imem_rdata};

  fetch_fifo #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .count      (count)
  );

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count != '0);
  assign out_inst  = out_valid ? head.inst : NOP_INST;
  assign out_pc    = out_valid ? head.pc   : '0;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: a depth-2 instance at RESET_PC 0 driven by directed
// and random stimulus against a reference PC stream, plus a depth-4 instance
// at RESET_PC FFFF_FFF8 that free-runs to exercise address wrap.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_inst, out_pc;
  logic        redirect_valid = 1'b0, out_valid, out_ready = 1'b0;

  ifetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  // ---------------- wrap DUT ----------------
  logic [31:0] w_imem_addr, w_imem_rdata, w_out_inst, w_out_pc;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_redirect_valid = 1'b0, w_out_ready = 1'b1, w_out_valid;

  ifetch_unit #(.RESET_PC(WRAP_PC), .BUF_DEPTH(4)) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (w_imem_addr),
    .imem_rdata     (w_imem_rdata),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .out_valid      (w_out_valid),
    .out_ready      (w_out_ready),
    .out_inst       (w_out_inst),
    .out_pc         (w_out_pc)
  );

  // Address-derived instruction word, distinct per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Instruction memories: word for the address presented last cycle.
  always @(posedge clk) begin
    imem_rdata   <= mem_word(imem_addr);
    w_imem_rdata <= mem_word(w_imem_addr);
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wrap_q[$];
  logic [31:0] gen_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  function automatic void restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = {pc[31:2], 2'b00};
    refill();
  endfunction

  // Drive one cycle of inputs (called just after a falling edge), score the
  // transfer that the coming rising edge performs, then wait for the next
  // falling edge. A transfer in a redirect cycle is discarded by the consumer.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic [31:0] e;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    if (rst_n && out_valid && rdy && !redir) begin
      e = exp_q.pop_front();
      check("acc_pc", out_pc, e);
      check("acc_inst", out_inst, mem_word(e));
      accepted++;
      refill();
    end
    if (redir) restart(rpc);
    @(negedge clk);
  endtask

  // Wrap-instance monitor: always ready, so every valid cycle is a transfer.
  int w_seen = 0;
  always @(negedge clk) begin
    #1;
    if (rst_n && w_out_valid && wrap_q.size() != 0) begin
      check("wrap_pc", w_out_pc, wrap_q[0]);
      check("wrap_inst", w_out_inst, mem_word(wrap_q[0]));
      void'(wrap_q.pop_front());
      w_seen++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int rand_start;
    logic [31:0] rpc;
    redirect_pc = 32'h0;
    for (int i = 0; i < 6; i++) wrap_q.push_back(WRAP_PC + 32'(4 * i));

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_inst", out_inst, NOP_INST);
    check("rst_pc", out_pc, 32'h0);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_waddr", w_imem_addr, WRAP_PC);
    @(negedge clk);
    restart(RST_PC);
    rst_n = 1'b1;

    // First issue on the first edge, first valid one cycle later.
    tick(1'b1, 1'b0, 32'h0);
    check("first_valid_early", {31'b0, out_valid}, 32'd0);
    check("first_addr", imem_addr, 32'h4);
    tick(1'b1, 1'b0, 32'h0);
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc", out_pc, 32'h0);

    // Steady state: one per cycle.
    for (int i = 0; i < 8; i++) begin
      check("steady_valid", {31'b0, out_valid}, 32'd1);
      tick(1'b1, 1'b0, 32'h0);
    end

    // Consumer stall: buffer fills, fetch pointer stops.
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0);
    check("stall_valid", {31'b0, out_valid}, 32'd1);
    check("stall_pc", out_pc, exp_q[0]);
    check("stall_addr", imem_addr, exp_q[0] + 32'(4 * DEPTH));
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'h0);

    // Redirect while buffer is full.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0000_0100);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_flush", {31'b0, out_valid}, 32'd0);
    tick(1'b1, 1'b0, 32'h0);
    check("redir_n1_valid", {31'b0, out_valid}, 32'd0);
    tick(1'b1, 1'b0, 32'h0);
    check("redir_n2_valid", {31'b0, out_valid}, 32'd1);
    check("redir_n2_pc", out_pc, 32'h100);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);

    // Unaligned redirect target.
    tick(1'b1, 1'b1, 32'h0000_0203);
    check("unalign_addr", imem_addr, 32'h200);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("unalign_pc", out_pc, 32'h200);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);

    // Back-to-back redirects: last wins.
    tick(1'b1, 1'b1, 32'h0000_0400);
    tick(1'b1, 1'b1, 32'h0000_0808);
    check("b2b_addr", imem_addr, 32'h808);
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("b2b_pc", out_pc, 32'h808);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h0);

    // Random consumer backpressure and redirects, including near the wrap.
    rand_start = accepted;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      else                           rpc = $urandom() & 32'h0000_FFFF;
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
    end
    check("rand_progress", {31'b0, (accepted - rand_start) > 100}, 32'd1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 32'h0);

    // Mid-operation reset discards everything at once.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_pc", out_pc, 32'h0);
    check("mid_rst_inst", out_inst, NOP_INST);
    check("mid_rst_addr", imem_addr, RST_PC);
    @(negedge clk);
    restart(RST_PC);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 32'h0);
    check("post_rst_pc", out_pc, 32'h0);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 32'h0);

    check("wrap_count", 32'(w_seen), 32'd6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, 2, output buffer entries; legal values 2 and 4 only.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  byte address to instruction memory; bits [1:0] always 0.
REQ-006 imem_rdata  input  32  instruction word for the address driven on the previous cycle (fixed 1-cycle latency, no enable, no handshake).
REQ-007 redirect_valid  input  1  one-cycle pulse: flush and restart fetch.
REQ-008 redirect_pc  input  32  restart address, sampled when redirect_valid=1.
REQ-009 out_valid  output  1  head buffer entry valid.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_inst  output  32  head instruction word.
REQ-012 out_pc  output  32  byte address of out_inst.

Function
REQ-013 State: fetch_pc (next address), inflight (1 bit, request issued last cycle), count (0..BUF_DEPTH), buffer of {pc, inst} entries.
REQ-014 imem_addr = fetch_pc at all times, combinationally.
REQ-015 pop = out_valid & out_ready; push = inflight & ~redirect_valid.
REQ-016 Issue when ~redirect_valid and (count + inflight - pop) < BUF_DEPTH; on issue fetch_pc <= fetch_pc + 4 and inflight <= 1, otherwise inflight <= 0.
REQ-017 On push, buffer stores {fetch address issued last cycle, imem_rdata} at tail.
REQ-018 Responses not marked inflight are ignored, even though imem_rdata still changes.
REQ-019 fetch_pc increment wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-020 out_valid = (count != 0); when empty, out_inst = 32'h0000_0013 and out_pc = 0.
REQ-021 Simultaneous push and pop when full is legal; count unchanged, order preserved.
REQ-022 Steady state with out_ready=1 and no redirect: one instruction per cycle, strictly increasing by 4.
REQ-023 Redirect at cycle N: buffer cleared, inflight cleared, response arriving at N discarded, fetch_pc <= {redirect_pc[31:2], 2'b00}, no issue at N.
REQ-024 A pop at cycle N (same cycle as redirect) completes normally; the consumer discards it.
REQ-025 Redirect latency: imem_addr = redirect target at N+1; first out_valid with out_pc = target at N+2.
REQ-026 Back-to-back redirects: the last one wins; no instruction from an earlier target reaches the output.
REQ-027 With out_ready=0, at most BUF_DEPTH entries plus 0 in flight; no entry is overwritten or lost.

Reset
REQ-028 While rst_n=0: fetch_pc = RESET_PC, inflight = 0, count = 0, out_valid = 0, out_inst = 32'h0000_0013, out_pc = 0, imem_addr = RESET_PC.
REQ-029 An assertion mid-operation discards buffer and in-flight state immediately.
REQ-030 The first issue is on the first rising edge after rst_n deasserts; first out_valid is one cycle later.

Structure
REQ-031 Shared package holds XLEN=32, NOP_INST=32'h0000_0013 and INST_BYTES=4; the unit imports them and defines no copies.
REQ-032 The buffer is a sub-module fetch_fifo (parameter BUF_DEPTH; push/pop/flush; count output; rst_n async); issue logic and fetch_pc stay in ifetch_unit.

Verification
REQ-033 Reset release, out_ready=1, imem model returns addr-derived words: out_pc 0,4,8,... back-to-back from the 2nd cycle after release.
REQ-034 out_ready=0 for 10 cycles: count saturates at BUF_DEPTH, fetch_pc stalls, then on release pcs continue with no gap or duplicate.
REQ-035 Redirect to 0x0000_0100 while full and inflight: next accepted out_pc = 0x100, exactly 2 cycles after the pulse.
REQ-036 Redirect to 0x0000_0203: imem_addr = 0x200, out_pc = 0x200.
REQ-037 RESET_PC=32'hFFFF_FFF8: out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 Randomized out_ready plus redirects against a reference PC model: every accepted {pc, inst} matches, none missing, none duplicated.
